// File: rtl/pkt_slot_allocator_pkg.sv
// Shared packet-buffer constants and the slot allocator state type.
package pkt_slot_allocator_pkg;

    localparam int unsigned PKT_NUM    = 32;
    localparam int unsigned PKT_AWIDTH = $clog2(PKT_NUM);

    typedef enum logic [1:0] {
        WAIT_STABLE,
        INIT,
        RUN
    } slot_alloc_state_t;

endpackage

// File: rtl/pkt_slot_allocator_arb.sv
// Two-requester round-robin arbiter; priority flips only on a contested grant.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    logic r_prio_b;
    logic w_contest;

    assign o_gnt_a   = i_en && i_req_a && (!i_req_b || !r_prio_b);
    assign o_gnt_b   = i_en && i_req_b && (!i_req_a ||  r_prio_b);
    assign w_contest = i_en && i_req_a && i_req_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_b <= 1'b0;
        end else if (w_contest) begin
            r_prio_b <= !r_prio_b;
        end
    end

endmodule

// File: rtl/pkt_slot_allocator.sv
// Free-list of packet-buffer slot IDs: seeded after reset, allocated from the
// head, refilled from two round-robin arbitrated release ports.
module pkt_slot_allocator
    import pkt_slot_allocator_pkg::*;
#(
    parameter int unsigned NUM_SLOTS     = PKT_NUM,
    parameter int unsigned AWIDTH        = PKT_AWIDTH,
    parameter int unsigned STABLE_CYCLES = 50,
    parameter int unsigned LOW_WM        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              alloc_valid,
    output logic [AWIDTH-1:0] alloc_data,
    input  logic              alloc_ready,
    input  logic              free_a_valid,
    input  logic [AWIDTH-1:0] free_a_data,
    output logic              free_a_ready,
    input  logic              free_b_valid,
    input  logic [AWIDTH-1:0] free_b_data,
    output logic              free_b_ready,
    output logic              init_done,
    output logic [AWIDTH:0]   free_count,
    output logic              almost_empty,
    output logic              overflow_err
);

    localparam int unsigned SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH+1)'(1);

    slot_alloc_state_t r_state, w_next_state;

    logic [SCW-1:0]    r_settle;
    logic [AWIDTH-1:0] r_mem [NUM_SLOTS];
    logic [AWIDTH-1:0] r_rd_ptr, r_wr_ptr;
    logic [AWIDTH:0]   r_count, w_next_count;
    logic              r_init_done, r_almost_empty, r_overflow;
    logic              w_run, w_alloc, w_gnt_a, w_gnt_b, w_free_acc, w_full, w_wr_en;
    logic [AWIDTH-1:0] w_wr_data;

    assign w_run = (r_state == RUN);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_run),
        .i_req_a (free_a_valid),
        .i_req_b (free_b_valid),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b)
    );

    assign free_a_ready = w_gnt_a;
    assign free_b_ready = w_gnt_b;
    assign w_free_acc   = w_gnt_a || w_gnt_b;
    assign w_full       = (r_count == (AWIDTH+1)'(NUM_SLOTS));
    assign alloc_valid  = w_run && (r_count != '0);
    assign alloc_data   = r_mem[r_rd_ptr];
    assign w_alloc      = alloc_valid && alloc_ready;

    assign init_done    = r_init_done;
    assign free_count   = r_count;
    assign almost_empty = r_almost_empty;
    assign overflow_err = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_STABLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            WAIT_STABLE: if (r_settle == SCW'(STABLE_CYCLES - 1)) w_next_state = INIT;
            INIT:        if (r_wr_ptr == AWIDTH'(NUM_SLOTS - 1))  w_next_state = RUN;
            RUN:         w_next_state = RUN;
            default:     w_next_state = WAIT_STABLE;
        endcase
    end

    // Seeding reuses the write pointer as the ID; a free into a full list is dropped.
    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_data    = r_wr_ptr;
        w_next_count = r_count;
        if (r_state == INIT) begin
            w_wr_en      = 1'b1;
            w_next_count = r_count + CNT_ONE;
        end else if (w_run) begin
            w_wr_en   = w_free_acc && !w_full;
            w_wr_data = w_gnt_a ? free_a_data : free_b_data;
            case ({w_wr_en, w_alloc})
                2'b10:   w_next_count = r_count + CNT_ONE;
                2'b01:   w_next_count = r_count - CNT_ONE;
                default: w_next_count = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle       <= '0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_init_done    <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
        end else begin
            if (r_state == WAIT_STABLE) r_settle <= r_settle + SCW'(1);
            if (w_wr_en)                r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
            if (w_alloc)                r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
            r_count        <= w_next_count;
            r_almost_empty <= (32'(w_next_count) < LOW_WM);
            if ((r_state == INIT) && (w_next_state == RUN)) r_init_done <= 1'b1;
            if (w_run && w_free_acc && w_full)              r_overflow  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
    end

endmodule

// File: tb/tb_pkt_slot_allocator.sv
// Self-checking bench for pkt_slot_allocator against a queue-based free-list model.
module tb_pkt_slot_allocator;

    localparam int unsigned NS = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_valid, alloc_ready;
    logic [AW-1:0] alloc_data;
    logic          free_a_valid, free_a_ready, free_b_valid, free_b_ready;
    logic [AW-1:0] free_a_data, free_b_data;
    logic          init_done, almost_empty, overflow_err;
    logic [AW:0]   free_count;

    pkt_slot_allocator #(
        .NUM_SLOTS     (NS),
        .AWIDTH        (AW),
        .STABLE_CYCLES (50),
        .LOW_WM        (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_data   (alloc_data),
        .alloc_ready  (alloc_ready),
        .free_a_valid (free_a_valid),
        .free_a_data  (free_a_data),
        .free_a_ready (free_a_ready),
        .free_b_valid (free_b_valid),
        .free_b_data  (free_b_data),
        .free_b_ready (free_b_ready),
        .init_done    (init_done),
        .free_count   (free_count),
        .almost_empty (almost_empty),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model: the free list as a FIFO of IDs plus priority and sticky error.
    logic [AW-1:0] m_q[$];
    logic [AW-1:0] m_held[$];
    bit            m_prio_b, m_ovf, m_ga, m_gb, m_hit;
    logic [AW-1:0] m_last;

    typedef struct {
        bit va; int unsigned da; bit vb; int unsigned db; bit ar;
        bit ra; bit rb; bit av; int unsigned ad; int unsigned cnt;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prio_b = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_seed();
        for (int unsigned i = 0; i < NS; i++) m_q.push_back(AW'(i));
    endtask

    task automatic model_step(input bit va, input logic [AW-1:0] da,
                              input bit vb, input logic [AW-1:0] db, input bit ar);
        bit full;
        m_ga = va && (!vb || !m_prio_b);
        m_gb = vb && (!va ||  m_prio_b);
        full = (m_q.size() == NS);
        m_hit = ar && (m_q.size() != 0);
        if (m_hit) m_last = m_q.pop_front();
        if (m_ga || m_gb) begin
            if (full) m_ovf = 1'b1;
            else      m_q.push_back(m_ga ? da : db);
        end
        if (va && vb) m_prio_b = !m_prio_b;
    endtask

    task automatic drive(input bit va, input int unsigned da, input bit vb,
                         input int unsigned db, input bit ar);
        free_a_valid = va;
        free_a_data  = AW'(da);
        free_b_valid = vb;
        free_b_data  = AW'(db);
        alloc_ready  = ar;
    endtask

    task automatic cyc(input bit va, input int unsigned da, input bit vb,
                       input int unsigned db, input bit ar);
        drive(va, da, vb, db, ar);
        #2;
        chk("alloc_valid", alloc_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("alloc_data", alloc_data, m_q[0]);
        model_step(va, AW'(da), vb, AW'(db), ar);
        chk("free_a_ready", free_a_ready, m_ga);
        chk("free_b_ready", free_b_ready, m_gb);
        @(posedge clk); #1;
        chk("free_count", free_count, m_q.size());
        chk("almost_empty", almost_empty, m_q.size() < 16);
        chk("overflow_err", overflow_err, m_ovf);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_alloc_valid"}, alloc_valid, 0);
        chk({tag, "_free_a_ready"}, free_a_ready, 0);
        chk({tag, "_free_b_ready"}, free_b_ready, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_free_count"}, free_count, 0);
        chk({tag, "_almost_empty"}, almost_empty, 1);
        chk({tag, "_overflow_err"}, overflow_err, 0);
    endtask

    task automatic release_and_seed(input string tag);
        int first_wr, done_at;
        first_wr = -1;
        done_at  = -1;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int n = 1; n <= 200 && done_at < 0; n++) begin
            @(posedge clk); #1;
            if (first_wr < 0 && free_count != 0) first_wr = n;
            if (init_done) done_at = n;
        end
        chk({tag, "_first_write_edge"}, first_wr, 51);
        chk({tag, "_init_done_edge"}, done_at, 82);
        chk({tag, "_seed_count"}, free_count, NS);
        chk({tag, "_seed_almost_empty"}, almost_empty, 0);
        model_reset();
        model_seed();
    endtask

    initial begin
        vecs[0] = '{1, 5, 1,  9, 0,  1, 0, 0, 0,  1};
        vecs[1] = '{1, 6, 1,  9, 0,  0, 1, 1, 5,  2};
        vecs[2] = '{1, 6, 1, 10, 0,  1, 0, 1, 5,  3};
        vecs[3] = '{0, 0, 1, 10, 0,  0, 1, 1, 5,  4};
        vecs[4] = '{0, 0, 0,  0, 1,  0, 0, 1, 5,  3};
        vecs[5] = '{0, 0, 0,  0, 1,  0, 0, 1, 9,  2};
        vecs[6] = '{0, 0, 0,  0, 1,  0, 0, 1, 6,  1};
        vecs[7] = '{0, 0, 0,  0, 1,  0, 0, 1, 10, 0};
        vecs[8] = '{1, 11, 1, 12, 0, 0, 1, 0, 0,  1};
        vecs[9] = '{0, 0, 0,  0, 1,  0, 0, 1, 12, 0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        drive(1, 1, 1, 2, 1);
        #1;
        chk_reset("por");

        release_and_seed("init1");

        for (int unsigned i = 0; i < NS; i++) cyc(0, 0, 0, 0, 1);
        chk("drained_valid", alloc_valid, 0);
        chk("drained_count", free_count, 0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].va, vecs[i].da, vecs[i].vb, vecs[i].db, vecs[i].ar);
            #2;
            chk($sformatf("vec%0d_ready_a", i), free_a_ready, vecs[i].ra);
            chk($sformatf("vec%0d_ready_b", i), free_b_ready, vecs[i].rb);
            chk($sformatf("vec%0d_alloc_valid", i), alloc_valid, vecs[i].av);
            if (vecs[i].av) chk($sformatf("vec%0d_alloc_data", i), alloc_data, vecs[i].ad);
            model_step(vecs[i].va, AW'(vecs[i].da), vecs[i].vb, AW'(vecs[i].db), vecs[i].ar);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_count", i), free_count, vecs[i].cnt);
        end

        cyc(1, 1, 0, 0, 0);
        cyc(1, 2, 0, 0, 0);
        cyc(0, 0, 1, 3, 0);
        cyc(1, 7, 0, 0, 1);
        chk("simul_count", free_count, 3);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        #2;
        chk("simul_tail_id", alloc_data, 7);
        cyc(0, 0, 0, 0, 1);

        for (int unsigned i = 0; i < NS; i++) begin
            if (i % 2 == 0) cyc(1, i, 0, 0, 0);
            else            cyc(0, 0, 1, i, 0);
        end
        chk("full_count", free_count, NS);
        cyc(1, 3, 0, 0, 0);
        chk("ovf_flag", overflow_err, 1);
        chk("ovf_count", free_count, NS);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("ovf_sticky", overflow_err, 1);
        m_held.delete();
        for (int unsigned i = 0; i < NS; i++) begin
            cyc(0, 0, 0, 0, 1);
            if (m_hit) m_held.push_back(m_last);
        end
        chk("ovf_drain_empty", alloc_valid, 0);

        for (int k = 0; k < 300; k++) begin
            bit va, vb, ar;
            int unsigned da, db;
            va = (m_held.size() > 0) && ($urandom_range(0, 2) != 0);
            vb = (m_held.size() > 1) && ($urandom_range(0, 2) != 0);
            da = va ? int'(m_held[0]) : 0;
            db = vb ? int'(m_held[1]) : 0;
            ar = 1'($urandom_range(0, 1));
            cyc(va, da, vb, db, ar);
            if (m_ga)      m_held.delete(0);
            else if (m_gb) m_held.delete(1);
            if (m_hit) m_held.push_back(m_last);
        end
        begin
            int unsigned seen[NS];
            int unsigned dups, uniq, guard;
            foreach (seen[i]) seen[i] = 0;
            guard = 0;
            while (m_held.size() > 0 && guard < 100) begin
                cyc(1, m_held[0], 0, 0, 0);
                if (m_ga) void'(m_held.pop_front());
                guard++;
            end
            chk("return_all", m_held.size(), 0);
            for (int unsigned i = 0; i < NS; i++) begin
                drive(0, 0, 0, 0, 1);
                #2;
                if (alloc_valid) seen[alloc_data]++;
                cyc(0, 0, 0, 0, 1);
            end
            dups = 0;
            uniq = 0;
            foreach (seen[i]) begin
                if (seen[i] > 1) dups++;
                if (seen[i] != 0) uniq++;
            end
            chk("wrap_no_dup", dups, 0);
            chk("wrap_all_ids", uniq, NS);
        end
        chk("init_done_sticky", init_done, 1);

        drive(1, 4, 1, 5, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset("midrun");
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
        end
        chk("midinit_count_before", free_count, 10);
        chk("midinit_done_before", init_done, 0);
        drive(1, 4, 1, 5, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset("midinit");
        release_and_seed("init2");
        chk("reseed_head", alloc_data, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got %0d, expected %0d", n_total, 0);
        $fatal(1);
    end

endmodule
